rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//  Write-side front end for the mips789 register file: merges the in-order pipeline writeback with
//  out-of-order late-load returns into the single write port (data/wraddress/wren) of reg_array.
//  Late returns are buffered in a small FIFO. A per-register pending scoreboard lets hazard logic stall.
// PARAMETERS
//  DEPTH  4   late-load FIFO entries; power of two, >=2
//  AW     5   register address width
//  DW     32  register data width
// PORTS
//  clock         in   1      system clock, all state on posedge
//  rst_n         in   1      asynchronous active-low reset
//  pause         in   1      pipeline stall; same signal reg_array receives
//  pl_wren       in   1      pipeline writeback valid
//  pl_wraddress  in   AW     pipeline destination register
//  pl_data       in   DW     pipeline write data
//  ld_issue      in   1      late load issued this cycle (scoreboard set)
//  ld_issue_addr in   AW     destination of issued late load
//  ld_valid      in   1      late-load return valid
//  ld_ready      out  1      FIFO can accept a return
//  ld_wraddress  in   AW     return destination register
//  ld_data       in   DW     return data
//  rf_wren       out  1      to reg_array wren
//  rf_wraddress  out  AW     to reg_array wraddress
//  rf_data       out  DW     to reg_array data
//  ld_count      out  log2(DEPTH)+1  FIFO occupancy
//  pending       out  32     per-register outstanding-late-load flags
// BEHAVIOUR
//  - Reset (async, rst_n=0): FIFO empty, ld_count=0, pending=0; rf_wren forced 0; ld_ready=1 on release.
//  - Reset mid-operation flushes queued returns; their data is lost; pending cleared.
//  - Accept: ld_valid && ld_ready at posedge pushes {addr,data}; ld_ready = (ld_count != DEPTH).
//    No full-bypass: a pop and a push in the same cycle do not relax ld_ready in that cycle.
//    Accepting is independent of pause. Return with ld_wraddress==0 is accepted and discarded.
//  - Write select (combinational, zero added latency; reg_array registers the inputs):
//    pause=1 -> rf_wren=0, no pop.
//    else pl_wren && pl_wraddress!=0 -> drive pipeline write; FIFO holds (pipeline has priority).
//    else FIFO non-empty -> drive head entry, pop at posedge.
//    else rf_wren=0. Pipeline write to R0 counts as no write; FIFO may drain that cycle.
//  - No same-cycle FIFO bypass: an entry pushed at edge N is drivable from cycle N+1.
//  - Ordering: FIFO entries are written in arrival order. rf_wraddress/rf_data hold the last
//    driven value when rf_wren=0.
//  - Simultaneous push and pop: both occur; ld_count unchanged.
//  - Protocol rules enforced by hazard unit, not checked here: at most one outstanding late load
//    per register; the pipeline never writes a pending register.
// CONFIGURATION
//  RF_WB_SCOREBOARD_EN defined: pending[r] is set at posedge on ld_issue && ld_issue_addr==r (r!=0).
//    It is cleared at the posedge on which the FIFO entry for r pops. Set wins over clear on the
//    same register in the same cycle. pending[0] is always 0.
//  Not defined: pending ties to 32'b0, ld_issue/ld_issue_addr are ignored, no scoreboard flops.
// STRUCTURE
//  mips789_defs.v gains `RF_WB_DEPTH and the source-select encodings `WB_SRC_NONE/PL/LD.
//  One sub-module, rf_wb_fifo: a DEPTH x (AW+DW) synchronous FIFO with push/pop/count.
//  Arbiter and scoreboard stay in rf_wb_arbiter.
// TESTING
//  1. Reset: assert rst_n=0 mid-cycle -> rf_wren=0, ld_ready=1, ld_count=0, pending=0 immediately.
//  2. ld_valid addr 5 data 32'hDEADBEEF, idle pipe -> next cycle rf_wren=1, addr 5, data DEADBEEF.
//     With the macro, pending[5] (set by prior ld_issue) clears at the following edge.
//  3. FIFO holds 1 entry, pl_wren to R3 data 32'h1234 -> pipeline write driven, ld_count stays 1.
//     Next cycle the FIFO entry is driven.
//  4. Keep pl_wren=1 to R7 and push 4 returns -> ld_count=4, ld_ready=0. Drop pl_wren ->
//     4 consecutive writes in arrival order, then ld_ready=1.
//  5. pause=1 with 2 entries queued -> rf_wren=0, ld_count stays 2. Push during pause -> ld_count 3.
//  6. Return to R0 -> accepted, never written. pl_wren to R0 with FIFO non-empty -> FIFO head drains.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and encodings for the register-file write-side arbiter.
// Holds the default late-load FIFO depth and the write-source selection enum.
// Feature macro used by the design: RF_WB_SCOREBOARD_EN.
package rf_wb_arbiter_pkg;

  localparam int RF_WB_DEPTH = 4;
  localparam int RF_AW       = 5;
  localparam int RF_DW       = 32;
  localparam int RF_NREGS    = 32;

  // Which source owns the register-file write port this cycle
  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_PL   = 2'd1,
    WB_SRC_LD   = 2'd2
  } wb_src_e;

  // One-hot register mask; R0 is hardwired zero so it never gets a bit
  function automatic logic [RF_NREGS-1:0] reg_mask(input logic [RF_AW-1:0] a);
    logic [RF_NREGS-1:0] m;
    m = '0;
    if (a != '0) m = RF_NREGS'(1) << a;
    return m;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bundle of pipeline writeback, late-load return, scoreboard and reg_array write signals.
// master = upstream pipeline / load unit side, slave = the arbiter.
// Pure wiring, no state.
interface rf_wb_arbiter_if
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = RF_WB_DEPTH,
  parameter int AW    = RF_AW,
  parameter int DW    = RF_DW
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          pause;
  logic          pl_wren;
  logic [AW-1:0] pl_wraddress;
  logic [DW-1:0] pl_data;
  logic          ld_issue;
  logic [AW-1:0] ld_issue_addr;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_wraddress;
  logic [DW-1:0] ld_data;
  logic          rf_wren;
  logic [AW-1:0] rf_wraddress;
  logic [DW-1:0] rf_data;
  logic [CW-1:0] ld_count;
  logic [31:0]   pending;

  modport master (
    output pause, pl_wren, pl_wraddress, pl_data,
    output ld_issue, ld_issue_addr, ld_valid, ld_wraddress, ld_data,
    input  ld_ready, rf_wren, rf_wraddress, rf_data, ld_count, pending
  );

  modport slave (
    input  pause, pl_wren, pl_wraddress, pl_data,
    input  ld_issue, ld_issue_addr, ld_valid, ld_wraddress, ld_data,
    output ld_ready, rf_wren, rf_wraddress, rf_data, ld_count, pending
  );

endinterface

// File: rtl/rf_wb_fifo.sv
// Purpose: DEPTH x W synchronous FIFO for late-load returns, with occupancy count.
// Latency: entry pushed at edge N is visible at the head from cycle N+1 (no bypass).
// Backpressure: push ignored when full, pop ignored when empty; caller gates on count.
module rf_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic                       clock,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [W-1:0]               i_dat,
  input  logic                       i_pop,
  output logic [W-1:0]               o_dat,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_push = i_push && (r_count != CW'(DEPTH));
  assign w_do_pop  = i_pop && (r_count != '0);

  // Storage needs no reset: the count alone decides which slots are live
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_dat;
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  assign o_dat   = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Purpose: merges pipeline writeback and buffered late-load returns onto the single reg_array write port.
// Latency: zero added on the write path; a late return is drivable the cycle after it is accepted.
// Backpressure: ld_ready drops when the FIFO is full (no same-cycle pop relief); pause blocks draining.
// Optional feature macro: RF_WB_SCOREBOARD_EN (per-register pending scoreboard).
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = RF_WB_DEPTH,
  parameter int AW    = RF_AW,
  parameter int DW    = RF_DW
) (
  input logic               clock,
  input logic               rst_n,
  rf_wb_arbiter_if.slave    wb
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = AW + DW;

  wb_src_e       w_src;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic [EW-1:0] w_head;
  logic [AW-1:0] w_head_addr;
  logic [DW-1:0] w_head_data;
  logic [CW-1:0] w_count;
  logic [AW-1:0] r_last_addr;
  logic [DW-1:0] r_last_data;

  assign wb.ld_ready = (w_count != CW'(DEPTH));
  // Returns aimed at R0 complete the handshake but are dropped before the FIFO
  assign w_push      = wb.ld_valid && wb.ld_ready && (wb.ld_wraddress != '0);
  assign wb.ld_count = w_count;

  rf_wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clock   (clock),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_dat   ({wb.ld_wraddress, wb.ld_data}),
    .i_pop   (w_pop),
    .o_dat   (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign {w_head_addr, w_head_data} = w_head;

  // Pick the write source: pause blocks all, pipeline beats FIFO, R0 pipeline writes yield
  always_comb begin
    w_src = WB_SRC_NONE;
    if (rst_n && !wb.pause) begin
      if (wb.pl_wren && (wb.pl_wraddress != '0)) w_src = WB_SRC_PL;
      else if (!w_empty)                          w_src = WB_SRC_LD;
    end
  end

  assign w_pop = (w_src == WB_SRC_LD);

  // Drive the write port; address/data hold their last driven value while idle
  always_comb begin
    wb.rf_wren      = (w_src != WB_SRC_NONE);
    wb.rf_wraddress = r_last_addr;
    wb.rf_data      = r_last_data;
    case (w_src)
      WB_SRC_PL: begin
        wb.rf_wraddress = wb.pl_wraddress;
        wb.rf_data      = wb.pl_data;
      end
      WB_SRC_LD: begin
        wb.rf_wraddress = w_head_addr;
        wb.rf_data      = w_head_data;
      end
      default: ;
    endcase
  end

  // Remember the last value placed on the write port
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_last_addr <= '0;
      r_last_data <= '0;
    end else if (w_src != WB_SRC_NONE) begin
      r_last_addr <= wb.rf_wraddress;
      r_last_data <= wb.rf_data;
    end
  end

`ifdef RF_WB_SCOREBOARD_EN
  logic [31:0] r_pending;
  logic [31:0] w_set;
  logic [31:0] w_clr;

  // Issue sets, pop of the matching entry clears; set is applied last so it wins
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (wb.ld_issue) w_set = reg_mask(wb.ld_issue_addr);
    if (w_pop)       w_clr = reg_mask(w_head_addr);
  end

  // Scoreboard flops; R0 never receives a bit from reg_mask
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= (r_pending & ~w_clr) | w_set;
  end

  assign wb.pending = r_pending;
`else
  logic w_unused_issue;
  assign w_unused_issue = ^{wb.ld_issue, wb.ld_issue_addr};
  assign wb.pending     = '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: vector table applied one cycle per row, plus reset sequences.
// Inputs change on the falling edge; outputs are sampled 2ns later, well before the rising edge.
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;

  logic clock = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clock = ~clock;

  rf_wb_arbiter_if #(.DEPTH(4), .AW(5), .DW(32)) bus ();

  rf_wb_arbiter #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .wb    (bus)
  );

  typedef struct {
    logic        pause;
    logic        plw;
    logic [4:0]  pla;
    logic [31:0] pld;
    logic        ldv;
    logic [4:0]  lda;
    logic [31:0] ldd;
    logic        iss;
    logic [4:0]  issa;
    logic        e_wren;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_rdy;
    logic [2:0]  e_cnt;
    logic [31:0] e_pend;
  } vec_t;

  vec_t vt[38];

  function automatic vec_t mk(
    input logic pause, input logic plw, input logic [4:0] pla, input logic [31:0] pld,
    input logic ldv, input logic [4:0] lda, input logic [31:0] ldd,
    input logic iss, input logic [4:0] issa,
    input logic e_wren, input logic [4:0] e_addr, input logic [31:0] e_data,
    input logic e_rdy, input logic [2:0] e_cnt, input logic [31:0] e_pend);
    vec_t v;
    v.pause = pause; v.plw = plw; v.pla = pla; v.pld = pld;
    v.ldv = ldv; v.lda = lda; v.ldd = ldd; v.iss = iss; v.issa = issa;
    v.e_wren = e_wren; v.e_addr = e_addr; v.e_data = e_data;
    v.e_rdy = e_rdy; v.e_cnt = e_cnt; v.e_pend = e_pend;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard flags only exist in the feature build
  function automatic logic [31:0] pend_exp(input logic [31:0] p);
`ifdef RF_WB_SCOREBOARD_EN
    return p;
`else
    return (p & 32'h0);
`endif
  endfunction

  task automatic drive(input vec_t v);
    bus.pause         = v.pause;
    bus.pl_wren       = v.plw;
    bus.pl_wraddress  = v.pla;
    bus.pl_data       = v.pld;
    bus.ld_valid      = v.ldv;
    bus.ld_wraddress  = v.lda;
    bus.ld_data       = v.ldd;
    bus.ld_issue      = v.iss;
    bus.ld_issue_addr = v.issa;
  endtask

  task automatic check_all(input string tag, input vec_t v);
    chk({tag, ".rf_wren"},      32'(bus.rf_wren),      32'(v.e_wren));
    chk({tag, ".rf_wraddress"}, 32'(bus.rf_wraddress), 32'(v.e_addr));
    chk({tag, ".rf_data"},      bus.rf_data,           v.e_data);
    chk({tag, ".ld_ready"},     32'(bus.ld_ready),     32'(v.e_rdy));
    chk({tag, ".ld_count"},     32'(bus.ld_count),     32'(v.e_cnt));
    chk({tag, ".pending"},      bus.pending,           pend_exp(v.e_pend));
  endtask

  vec_t idle;

  initial begin
    // Columns: pause plw pla pld | ldv lda ldd | iss issa || wren addr data rdy cnt pend
    vt[0]  = mk(0,0,5'd0,0,           0,5'd0,0,              0,5'd0,  0,5'd0,32'h0,1,3'd0,32'h0);
    vt[1]  = mk(0,0,5'd0,0,           0,5'd0,0,              1,5'd5,  0,5'd0,32'h0,1,3'd0,32'h0);
    vt[2]  = mk(0,0,5'd0,0,           1,5'd5,32'hDEADBEEF,   0,5'd0,  0,5'd0,32'h0,1,3'd0,32'h20);
    vt[3]  = mk(0,0,5'd0,0,           0,5'd0,0,              0,5'd0,  1,5'd5,32'hDEADBEEF,1,3'd1,32'h20);
    vt[4]  = mk(0,0,5'd0,0,           0,5'd0,0,              0,5'd0,  0,5'd5,32'hDEADBEEF,1,3'd0,32'h0);
    vt[5]  = mk(0,0,5'd0,0,           1,5'd9,32'h99,         1,5'd9,  0,5'd5,32'hDEADBEEF,1,3'd0,32'h0);
    vt[6]  = mk(0,1,5'd3,32'h1234,    0,5'd0,0,              0,5'd0,  1,5'd3,32'h1234,1,3'd1,32'h200);
    vt[7]  = mk(0,0,5'd0,0,           0,5'd0,0,              0,5'd0,  1,5'd9,32'h99,1,3'd1,32'h200);
    vt[8]  = mk(0,0,5'd0,0,           0,5'd0,0,              0,5'd0,  0,5'd9,32'h99,1,3'd0,32'h0);
    vt[9]  = mk(0,1,5'd7,32'h77,      1,5'd10,32'hA0,        0,5'd0,  1,5'd7,32'h77,1,3'd0,32'h0);
    vt[10] = mk(0,1,5'd7,32'h77,      1,5'd11,32'hA1,        0,5'd0,  1,5'd7,32'h77,1,3'd1,32'h0);
    vt[11] = mk(0,1,5'd7,32'h77,      1,5'd12,32'hA2,        0,5'd0,  1,5'd7,32'h77,1,3'd2,32'h0);
    vt[12] = mk(0,1,5'd7,32'h77,      1,5'd13,32'hA3,        0,5'd0,  1,5'd7,32'h77,1,3'd3,32'h0);
    vt[13] = mk(0,1,5'd7,32'h77,      1,5'd14,32'hA4,        0,5'd0,  1,5'd7,32'h77,0,3'd4,32'h0);
    vt[14] = mk(0,0,5'd0,0,           1,5'd15,32'hB5,        0,5'd0,  1,5'd10,32'hA0,0,3'd4,32'h0);
    vt[15] = mk(0,0,5'd0,0,           0,5'd0,0,              0,5'd0,  1,5'd11,32'hA1,1,3'd3,32'h0);
    vt[16] = mk(0,0,5'd0,0,           0,5'd0,0,              0,5'd0,  1,5'd12,32'hA2,1,3'd2,32'h0);
    vt[17] = mk(0,0,5'd0,0,           0,5'd0,0,              0,5'd0,  1,5'd13,32'hA3,1,3'd1,32'h0);
    vt[18] = mk(0,0,5'd0,0,           0,5'd0,0,              0,5'd0,  0,5'd13,32'hA3,1,3'd0,32'h0);
    vt[19] = mk(0,0,5'd0,0,           1,5'd16,32'h16,        0,5'd0,  0,5'd13,32'hA3,1,3'd0,32'h0);
    vt[20] = mk(1,0,5'd0,0,           1,5'd17,32'h17,        0,5'd0,  0,5'd13,32'hA3,1,3'd1,32'h0);
    vt[21] = mk(1,1,5'd3,32'h55,      0,5'd0,0,              0,5'd0,  0,5'd13,32'hA3,1,3'd2,32'h0);
    vt[22] = mk(1,0,5'd0,0,           1,5'd18,32'h18,        0,5'd0,  0,5'd13,32'hA3,1,3'd2,32'h0);
    vt[23] = mk(0,0,5'd0,0,           0,5'd0,0,              0,5'd0,  1,5'd16,32'h16,1,3'd3,32'h0);
    vt[24] = mk(0,0,5'd0,0,           1,5'd19,32'h19,        0,5'd0,  1,5'd17,32'h17,1,3'd2,32'h0);
    vt[25] = mk(0,0,5'd0,0,           0,5'd0,0,              0,5'd0,  1,5'd18,32'h18,1,3'd2,32'h0);
    vt[26] = mk(0,0,5'd0,0,           0,5'd0,0,              0,5'd0,  1,5'd19,32'h19,1,3'd1,32'h0);
    vt[27] = mk(0,0,5'd0,0,           1,5'd0,32'hBAD,        0,5'd0,  0,5'd19,32'h19,1,3'd0,32'h0);
    vt[28] = mk(0,0,5'd0,0,           0,5'd0,0,              0,5'd0,  0,5'd19,32'h19,1,3'd0,32'h0);
    vt[29] = mk(0,0,5'd0,0,           1,5'd20,32'h20,        0,5'd0,  0,5'd19,32'h19,1,3'd0,32'h0);
    vt[30] = mk(0,1,5'd0,32'hBAD0,    0,5'd0,0,              0,5'd0,  1,5'd20,32'h20,1,3'd1,32'h0);
    vt[31] = mk(0,0,5'd0,0,           0,5'd0,0,              0,5'd0,  0,5'd20,32'h20,1,3'd0,32'h0);
    vt[32] = mk(0,0,5'd0,0,           1,5'd21,32'h21,        1,5'd21, 0,5'd20,32'h20,1,3'd0,32'h0);
    vt[33] = mk(0,0,5'd0,0,           0,5'd0,0,              1,5'd21, 1,5'd21,32'h21,1,3'd1,32'h200000);
    vt[34] = mk(0,0,5'd0,0,           0,5'd0,0,              1,5'd0,  0,5'd21,32'h21,1,3'd0,32'h200000);
    vt[35] = mk(0,0,5'd0,0,           1,5'd21,32'h2121,      0,5'd0,  0,5'd21,32'h21,1,3'd0,32'h200000);
    vt[36] = mk(0,0,5'd0,0,           0,5'd0,0,              0,5'd0,  1,5'd21,32'h2121,1,3'd1,32'h200000);
    vt[37] = mk(0,0,5'd0,0,           0,5'd0,0,              0,5'd0,  0,5'd21,32'h2121,1,3'd0,32'h0);
    idle   = vt[0];

    // Power-on reset with a live pipeline write that must be masked
    drive(idle);
    bus.pl_wren      = 1'b1;
    bus.pl_wraddress = 5'd3;
    bus.pl_data      = 32'h3333;
    #1 rst_n = 1'b0;
    #2;
    chk("por.rf_wren",  32'(bus.rf_wren),  32'd0);
    chk("por.ld_ready", 32'(bus.ld_ready), 32'd1);
    chk("por.ld_count", 32'(bus.ld_count), 32'd0);
    chk("por.pending",  bus.pending,       32'd0);
    @(negedge clock);
    drive(idle);
    rst_n = 1'b1;

    // Table: one row per cycle
    for (int i = 0; i < 38; i++) begin
      @(negedge clock);
      drive(vt[i]);
      #2;
      check_all($sformatf("vec%0d", i), vt[i]);
    end

    // Reset in the middle of operation with two queued returns
    @(negedge clock);
    drive(idle);
    bus.pause = 1'b1;
    bus.ld_issue = 1'b1;  bus.ld_issue_addr = 5'd22;
    bus.ld_valid = 1'b1;  bus.ld_wraddress  = 5'd22; bus.ld_data = 32'hC0FFEE22;
    @(negedge clock);
    drive(idle);
    bus.pause = 1'b1;
    bus.ld_valid = 1'b1;  bus.ld_wraddress  = 5'd23; bus.ld_data = 32'h23;
    @(negedge clock);
    drive(idle);
    bus.pause = 1'b1;
    #2;
    chk("mid.pre_count",   32'(bus.ld_count), 32'd2);
    chk("mid.pre_pending", bus.pending,       pend_exp(32'h400000));
    bus.pause        = 1'b0;
    bus.pl_wren      = 1'b1;
    bus.pl_wraddress = 5'd3;
    rst_n            = 1'b0;
    #1;
    chk("mid.rf_wren",      32'(bus.rf_wren),      32'd0);
    chk("mid.ld_ready",     32'(bus.ld_ready),     32'd1);
    chk("mid.ld_count",     32'(bus.ld_count),     32'd0);
    chk("mid.pending",      bus.pending,           32'd0);
    chk("mid.rf_wraddress", 32'(bus.rf_wraddress), 32'd0);
    @(negedge clock);
    drive(idle);
    rst_n = 1'b1;
    #2;
    chk("post.rf_wren",   32'(bus.rf_wren),  32'd0);
    chk("post.ld_count",  32'(bus.ld_count), 32'd0);
    chk("post.rf_data",   bus.rf_data,       32'd0);
    @(negedge clock);
    #2;
    chk("post2.rf_wren",  32'(bus.rf_wren),  32'd0);
    chk("post2.ld_ready", 32'(bus.ld_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
